mxvt_seq_nnbit_jkdim: RTL
=========================

# mxvt_seq_nnbit_jkdim

Sequential transposed matrix-vector multiplier for the fc_layer backward path. It computes o = Wᵀ·e, where W is the same J×K signed weight matrix, packed the same way, that the forward fully-connected layer uses, and e is a J-element signed error vector. One row of W is folded into K accumulators per clock, so a full result takes J cycles plus control overhead. The block sits next to the combinational forward mxv and reuses its g_input packing, so one weight bus feeds both directions.

## Interface
- N, 8, signed element bit-width of W and e
- J, 3, rows of W; length of e
- K, 3, columns of W; length of o
- L, 2*N+J-1, signed width of each output element; derived, do not override

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- g_input  in  J*K*N  W[r][c] = g_input[(r*K+c+1)*N-1 -: N], signed
- e_input  in  J*N  e[r] = e_input[(r+1)*N-1 -: N], signed
- busy  out  1  high from the edge that accepts start until the edge that raises done
- done  out  1  one-cycle pulse; o is valid from this cycle on
- o  out  K*L  o[c] = o[(c+1)*L-1 -: L] = Σ_r W[r][c]*e[r], signed, registered

## Operation
- Clock is clk; reset is rst_n, asynchronous and active-low.
- FSM states: IDLE, RUN, FIN.
- IDLE with start=1:
  - latch g_input and e_input into internal registers; inputs may change after this edge
  - clear all K accumulators; row counter cnt←0; busy←1; go to RUN
- RUN, each edge:
  - acc[c] ← acc[c] + sext(W[cnt][c]*e[cnt]) for all c in parallel
  - cnt++
  - after the edge that adds row J-1, go to FIN
- FIN: o ← acc; done←1 for exactly one cycle; busy←0; go to IDLE.
- Arithmetic:
  - each product is a signed N×N→2N multiply, sign-extended to L bits
  - accumulation is in L bits and cannot overflow for any inputs
- Between runs, o holds its last value; it changes only at the FIN edge.
- start while busy=1 is ignored; no queuing.
- start=1 in the cycle done=1: the state is already IDLE, so the start is accepted. o keeps the previous result until the new run's FIN edge.
- start held high continuously gives back-to-back runs with one IDLE cycle between them.
- Reset (any state, including mid-RUN):
  - state←IDLE, cnt←0, acc←0, o←0, busy←0, done←0
  - any in-flight run is discarded
- J=1 is legal: RUN lasts one cycle.

## Timing
- Edge 0 accepts start.
- Edges 1..J are accumulate steps.
- Edge J+1 is FIN: o is updated and done rises.
- Latency from the start-accepting edge to done visible: J+1 cycles. N=8, J=3 gives 4.
- busy is high for J+1 cycles per run.
- Minimum start-to-start spacing: J+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: busy=0, done=0, o=0.

## Test plan
- All-ones: N=8, J=3, K=3, W all 1, e=[1,2,3]. Pulse start → done exactly 4 cycles later, o=[6,6,6], busy high for 4 cycles.
- Transpose check:
  - W rows: [1,2,3], [4,5,6], [7,8,9]; e=[1,0,-1]
  - required: o=[-6,-6,-6]
  - this vector must differ from the forward W·e result [-2,-2,-2]
- Extremes:
  - W all -128, e all -128 → o=[49152]×3 in L=18 bits
  - W all 127, e all -128 → o=[-48768]×3
- Input isolation and busy-ignore:
  - after start, change g_input and e_input to random values and pulse start mid-RUN
  - required: result matches the originally latched operands; exactly one done
- Reset mid-run: drop rst_n in RUN cycle 2 → busy=0, done=0, o=0 immediately; no done ever follows for that run.
- Back-to-back: hold start high for two runs with different e → done pulses 5 cycles apart. o shows the first result, then the second; never a partial sum.

Source files
------------

// File: rtl/mxvt_seq_nnbit_jkdim.sv
// Sequential transposed matrix-vector multiplier: o = W^T * e.
// Folds one weight row into K accumulators per clock.
module mxvt_seq_nnbit_jkdim #(
  parameter int N = 8,
  parameter int J = 3,
  parameter int K = 3,
  localparam int L = 2*N+J-1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [J*K*N-1:0] g_input,
  input  logic [J*N-1:0]   e_input,
  output logic             busy,
  output logic             done,
  output logic [K*L-1:0]   o
);

  localparam int P  = 2*N;
  localparam int CW = (J > 1) ? $clog2(J) : 1;
  localparam logic [CW-1:0] LAST = CW'(J-1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state;

  logic [CW-1:0]         cnt;
  logic signed [N-1:0]   w_q [J][K];
  logic signed [N-1:0]   e_q [J];
  logic signed [L-1:0]   acc [K];
  logic signed [L-1:0]   o_q [K];
  logic signed [P-1:0]   prod [K];

  // Operands widened before the multiply so the product is full 2N bits
  always_comb begin
    for (int c = 0; c < K; c++) begin
      prod[c] = P'(w_q[cnt][c]) * P'(e_q[cnt]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int c = 0; c < K; c++) begin
        acc[c] <= '0;
        o_q[c] <= '0;
      end
      for (int r = 0; r < J; r++) begin
        e_q[r] <= '0;
        for (int c = 0; c < K; c++) begin
          w_q[r][c] <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int r = 0; r < J; r++) begin
              e_q[r] <= e_input[(r+1)*N-1 -: N];
              for (int c = 0; c < K; c++) begin
                w_q[r][c] <= g_input[(r*K+c+1)*N-1 -: N];
              end
            end
            for (int c = 0; c < K; c++) begin
              acc[c] <= '0;
            end
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          for (int c = 0; c < K; c++) begin
            acc[c] <= acc[c] + L'(prod[c]);
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIN;
          end
        end
        FIN: begin
          for (int c = 0; c < K; c++) begin
            o_q[c] <= acc[c];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < K; c++) begin : g_out
    assign o[(c+1)*L-1 -: L] = o_q[c];
  end

endmodule
